mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 17 +
 rtl/mult_arbiter_mymult18.sv | 54 +++++
 rtl/mult_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: default sizes, FSM state
// encoding and the watchdog limit for a multiplication in flight.
package mult_arbiter_pkg;

  localparam int N_REQ = 4;   // default number of requesters
  localparam int W     = 18;  // default operand width (product is 2*W)

  // Two-bit state encoding of the arbiter FSM.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // RUN cycles tolerated before the multiplier is declared hung.
  localparam logic [4:0] WD_LIMIT = 5'd24;

endpackage

// File: rtl/mult_arbiter_mymult18.sv
// myMult18: sequential shift-and-add unsigned multiplier.
// While i_start is low it latches the operands and clears itself; while
// i_start is high it runs one partial product per cycle and then raises
// o_done, holding o_done and o_prod until i_start drops.
module myMult18 #(
  parameter int W = mult_arbiter_pkg::W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);

  localparam int CNTW = $clog2(W + 1);

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;
  logic           r_done;

  // Operand load when idle, one shift-and-add step per cycle when started.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else if (!i_start) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else if (r_cnt < CNTW'(W)) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end else begin
      r_done   <= 1'b1;
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential multiplier among N_REQ requesters.
// Round-robin grant in IDLE, one LOAD cycle for the multiplier to latch the
// registered operands, RUN under a watchdog, and a one-cycle DONE that
// presents the result to the granted requester.
module mult_arbiter #(
  parameter int N_REQ = mult_arbiter_pkg::N_REQ,
  parameter int W     = mult_arbiter_pkg::W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] res_valid,
  output logic [2*W-1:0]   res,
  output logic             busy,
  output logic             err
);

  import mult_arbiter_pkg::*;

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  r_last;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_res_valid;
  logic [2*W-1:0]   r_res;
  logic             r_err;
  logic             r_calc_start;
  logic [4:0]       r_wd;

  logic [N_REQ-1:0][W-1:0] w_a_lane;
  logic [N_REQ-1:0][W-1:0] w_b_lane;
  logic [IDXW-1:0]  w_grant_idx;
  logic             w_done;
  logic [2*W-1:0]   w_prod;

  assign w_a_lane = a_in;
  assign w_b_lane = b_in;

  // First requester found searching upward from last+1, wrapping around.
  function automatic logic [IDXW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    logic            found;
    int              cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      if (!found && r[IDXW'(cand)]) begin
        pick  = IDXW'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Round-robin winner among the current requests.
  // NOTE: every always_comb output is assigned first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    w_grant_idx = '0;
    w_grant_idx = rr_pick(req, r_last);
  end

  // Arbiter FSM: grant, load, run under watchdog, present result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_last       <= IDXW'(N_REQ - 1);
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_ack        <= '0;
      r_res_valid  <= '0;
      r_res        <= '0;
      r_err        <= 1'b0;
      r_calc_start <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_ack        <= '0;
      r_res_valid  <= '0;
      r_err        <= 1'b0;
      r_calc_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_idx   <= w_grant_idx;
            r_last  <= w_grant_idx;
            r_op_a  <= w_a_lane[w_grant_idx];
            r_op_b  <= w_b_lane[w_grant_idx];
            r_ack   <= N_REQ'(1) << w_grant_idx;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_wd         <= '0;
          r_calc_start <= 1'b1;
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          if (w_done) begin
            r_res       <= w_prod;
            r_res_valid <= N_REQ'(1) << r_idx;
            r_state     <= ST_DONE;
          end else if (r_wd == WD_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wd         <= r_wd + 5'd1;
            r_calc_start <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  myMult18 #(.W(W)) u_mult (
    .CLK     (CLK),
    .RST     (RST),
    .i_start (r_calc_start),
    .i_a     (r_op_a),
    .i_b     (r_op_b),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );

  assign ack       = r_ack;
  assign res_valid = r_res_valid;
  assign res       = r_res;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule
